// File: rtl/sdft_inverse_synth.sv
// Sliding-DFT synthesis stage: averages the real parts of one framed bin stream into a single time sample.
// Optional framing checks are compiled in with `define SDFT_INVERSE_FRAME_CHECK_EN.
module sdft_inverse_synth #(
    parameter int N   = 256,
    parameter int IDW = 32,
    parameter int DW  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2*IDW-1:0]      data_i,
    input  logic                  sob_i,
    input  logic                  eob_i,
    input  logic                  valid_i,
    output logic signed [DW-1:0]  data_o,
    output logic                  valid_o,
    output logic                  sat_o,
    output logic                  frame_err_o
);

    localparam int LOGN = $clog2(N);
    localparam int AW   = IDW + LOGN;
    localparam int CW   = LOGN + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

`ifdef SDFT_INVERSE_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic signed [AW:0] HALF = (AW+1)'(N / 2);
    localparam logic signed [AW:0] MAXV = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [CW-1:0]      CNT_FULL = CW'(N);

    // Round half up, then arithmetic divide by N; one guard bit keeps the bias from overflowing.
    function automatic logic signed [AW:0] round_mean(input logic signed [AW-1:0] sum);
        logic signed [AW:0] biased;
        biased = {sum[AW-1], sum} + HALF;
        return biased >>> LOGN;
    endfunction

    // Returns {clipped_flag, sample}.
    function automatic logic [DW:0] sat_clip(input logic signed [AW:0] v);
        if (v > MAXV)
            return {1'b1, 1'b0, {(DW-1){1'b1}}};
        else if (v < MINV)
            return {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, v[DW-1:0]};
    endfunction

    logic signed [IDW-1:0] re_p0;
    logic signed [AW-1:0]  re_ext;
    logic [IDW-1:0]        im_unused;

    assign re_p0     = data_i[IDW-1:0];
    assign re_ext    = {{LOGN{re_p0[IDW-1]}}, re_p0};
    assign im_unused = data_i[2*IDW-1:IDW];

    logic [0:0]           state_p0, state_n;
    logic signed [AW-1:0] acc_p0, acc_n, acc_sum;
    logic [CW-1:0]        cnt_p0, cnt_n, cnt_inc;
    logic                 close, err;
    logic signed [AW-1:0] sum_close;
    logic [DW:0]          clip;

    assign acc_sum = acc_p0 + re_ext;
    assign cnt_inc = cnt_p0 + CW'(1);

    always_comb begin
        state_n   = state_p0;
        acc_n     = acc_p0;
        cnt_n     = cnt_p0;
        close     = 1'b0;
        err       = 1'b0;
        sum_close = '0;
        if (valid_i) begin
            if (sob_i) begin
                // A sob always opens a new frame, abandoning any frame in progress.
                if (state_p0 == S_ACCUM)
                    err = CHECK_EN;
                if (eob_i) begin
                    state_n = S_IDLE;
                    if (CHECK_EN) begin
                        err = 1'b1;
                    end else begin
                        close     = 1'b1;
                        sum_close = re_ext;
                    end
                end else begin
                    state_n = S_ACCUM;
                    acc_n   = re_ext;
                    cnt_n   = CW'(1);
                end
            end else if (state_p0 == S_ACCUM) begin
                if (eob_i) begin
                    state_n   = S_IDLE;
                    sum_close = acc_sum;
                    if (!CHECK_EN || cnt_inc == CNT_FULL)
                        close = 1'b1;
                    else
                        err = 1'b1;
                end else if (CHECK_EN && cnt_inc == CNT_FULL) begin
                    state_n = S_IDLE;
                    err     = 1'b1;
                end else begin
                    acc_n = acc_sum;
                    cnt_n = cnt_inc;
                end
            end else begin
                err = CHECK_EN;
            end
        end
    end

    assign clip = sat_clip(round_mean(sum_close));

    // ---- stage p0: frame accumulation ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p0 <= S_IDLE;
            acc_p0   <= '0;
            cnt_p0   <= '0;
        end else begin
            state_p0 <= state_n;
            acc_p0   <= acc_n;
            cnt_p0   <= cnt_n;
        end
    end

    // ---- stage p1: registered sample output ----
    logic signed [DW-1:0] data_p1;
    logic                 vld_p1, sat_p1, err_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            sat_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= close;
            sat_p1 <= close & clip[DW];
            err_p1 <= err;
            if (close)
                data_p1 <= clip[DW-1:0];
        end
    end

    assign data_o      = data_p1;
    assign valid_o     = vld_p1;
    assign sat_o       = sat_p1;
    assign frame_err_o = err_p1;

endmodule
